// File: rtl/sr_muldiv_pkg.sv
// sr_muldiv_pkg: shared constants for the RV32M multiply/divide unit.
//   - RV32M funct3 op codes and the funct7 value used by decode
//   - FSM state encoding
//   - helpers classifying an op (divide?, which operands are signed)
package sr_muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    // funct7 that marks an OP-class instruction as RV32M
    localparam logic [6:0] RVM_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        RVM_MUL    = 3'b000,
        RVM_MULH   = 3'b001,
        RVM_MULHSU = 3'b010,
        RVM_MULHU  = 3'b011,
        RVM_DIV    = 3'b100,
        RVM_DIVU   = 3'b101,
        RVM_REM    = 3'b110,
        RVM_REMU   = 3'b111
    } rvm_op_e;

    typedef enum logic [1:0] {
        SR_MD_IDLE = 2'd0,
        SR_MD_CALC = 2'd1,
        SR_MD_DONE = 2'd2
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM/REMU are the divide ops with funct3[1] set
    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == RVM_MULH) || (f3 == RVM_MULHSU) ||
               (f3 == RVM_DIV)  || (f3 == RVM_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == RVM_MULH) || (f3 == RVM_DIV) || (f3 == RVM_REM);
    endfunction

endpackage

// File: rtl/sr_muldiv_sign.sv
// sr_muldiv_sign: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
//   i_val [W-1:0] : input value
//   i_neg         : 1 = output the two's-complement negation of i_val
//   o_val [W-1:0] : i_val or -i_val
module sr_muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (-i_val) : i_val;

endmodule

// File: rtl/sr_muldiv.sv
// sr_muldiv: iterative RV32M multiply/divide unit feeding register-file
// write port 3. One result bit per cycle over 32 CALC cycles; divide by
// zero and signed overflow are resolved at start and finish next cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, flush      : request (sampled in IDLE), synchronous abort
//   funct3            : RV32M op select
//   op_a, op_b, rd_in : rs1/rs2 values and destination register
//   busy, done        : unit occupied, one-cycle completion pulse
//   wb_addr/data/we   : write-back request; we = done && addr != 0
module sr_muldiv
    import sr_muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state, w_next;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic              r_sign_a, r_sign_b;
    logic [XLEN-1:0]   r_mag_a, r_mag_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;      // product, or {unused, dividend/quotient}
    logic [XLEN-1:0]   r_rem;      // partial remainder (always < divisor)
    logic              r_special;
    logic [XLEN-1:0]   r_spec_data;
    logic [XLEN-1:0]   r_wb_data;
    logic [4:0]        r_wb_addr;

    // ---------------- operand classification ----------------
    logic            w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div0, w_ovf, w_special, w_accept;
    logic [XLEN-1:0] w_spec_data;

    assign w_neg_a = a_signed(funct3) & op_a[XLEN-1];
    assign w_neg_b = b_signed(funct3) & op_b[XLEN-1];

    sr_muldiv_sign #(.W(XLEN)) u_abs_a (.i_val(op_a), .i_neg(w_neg_a), .o_val(w_mag_a));
    sr_muldiv_sign #(.W(XLEN)) u_abs_b (.i_val(op_b), .i_neg(w_neg_b), .o_val(w_mag_b));

    assign w_div0    = is_div(funct3) && (op_b == '0);
    assign w_ovf     = ((funct3 == RVM_DIV) || (funct3 == RVM_REM)) &&
                       (op_a == INT_MIN) && (op_b == '1);
    assign w_special = w_div0 || w_ovf;
    // div0: quotient all ones, remainder is the raw dividend.
    // overflow: quotient INT_MIN, remainder 0.
    assign w_spec_data = w_div0 ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0 : INT_MIN);

    assign w_accept = (r_state == SR_MD_IDLE) && start && !flush;

    // ---------------- per-bit iteration ----------------
    // Multiply: add multiplicand into the high half when the multiplier
    // LSB (held in the low half) is set, then shift the whole thing right.
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mag_a : '0)};
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Divide: restoring step. The 33-bit shifted remainder is compared
    // against the divisor; on success the 32-bit difference is exact.
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub, w_rem_next;
    logic [2*XLEN-1:0] w_div_next;
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_ge       = (w_shift >= {1'b0, r_mag_b});
    assign w_sub      = w_shift[XLEN-1:0] - r_mag_b;
    assign w_rem_next = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign w_div_next = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_ge};

    // ---------------- result sign fix-up and select ----------------
    logic [2*XLEN-1:0] w_fix_in, w_fix_out;
    logic              w_fix_neg;
    logic [XLEN-1:0]   w_result;

    always_comb begin
        w_fix_in  = r_acc;
        w_fix_neg = r_sign_a ^ r_sign_b;
        if (is_rem(r_funct3)) begin
            // remainder follows the dividend's sign
            w_fix_in  = {{XLEN{1'b0}}, r_rem};
            w_fix_neg = r_sign_a;
        end else if (is_div(r_funct3)) begin
            w_fix_in  = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
        end
    end

    sr_muldiv_sign #(.W(2*XLEN)) u_fix (.i_val(w_fix_in), .i_neg(w_fix_neg), .o_val(w_fix_out));

    always_comb begin
        if (r_special)
            w_result = r_spec_data;
        else if (!is_div(r_funct3) && (r_funct3 != RVM_MUL))
            w_result = w_fix_out[2*XLEN-1:XLEN];
        else
            w_result = w_fix_out[XLEN-1:0];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SR_MD_IDLE;
        else        r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = SR_MD_IDLE;
        end else begin
            unique case (r_state)
                SR_MD_IDLE: if (start) w_next = w_special ? SR_MD_DONE : SR_MD_CALC;
                SR_MD_CALC: if (r_cnt == '0) w_next = SR_MD_DONE;
                SR_MD_DONE: w_next = SR_MD_IDLE;
                default:    w_next = SR_MD_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // wb_addr/wb_data show the live result in DONE and the captured copy
    // afterwards, so they hold their last value between operations.
    always_comb begin
        busy    = (r_state != SR_MD_IDLE);
        done    = (r_state == SR_MD_DONE) && !flush;
        wb_addr = (r_state == SR_MD_DONE) ? r_rd     : r_wb_addr;
        wb_data = (r_state == SR_MD_DONE) ? w_result : r_wb_data;
        wb_we   = done && (r_rd != '0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3    <= '0;
            r_rd        <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_special   <= 1'b0;
            r_spec_data <= '0;
            r_wb_data   <= '0;
            r_wb_addr   <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_funct3    <= funct3;
                r_rd        <= rd_in;
                r_sign_a    <= w_neg_a;
                r_sign_b    <= w_neg_b;
                r_mag_a     <= w_mag_a;
                r_mag_b     <= w_mag_b;
                r_cnt       <= CNT_INIT;
                // low half seeds the multiplier or the dividend
                r_acc       <= {{XLEN{1'b0}}, (is_div(funct3) ? w_mag_a : w_mag_b)};
                r_rem       <= '0;
                r_special   <= w_special;
                r_spec_data <= w_spec_data;
            end else if (r_state == SR_MD_CALC) begin
                r_cnt <= r_cnt - 1'b1;
                if (is_div(r_funct3)) begin
                    r_acc <= w_div_next;
                    r_rem <= w_rem_next;
                end else begin
                    r_acc <= w_mul_next;
                end
            end else if (r_state == SR_MD_DONE) begin
                r_wb_data <= w_result;
                r_wb_addr <= r_rd;
            end
        end
    end

endmodule

// File: tb/tb_sr_muldiv.sv
module tb_sr_muldiv;
    import sr_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr_muldiv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_we(wb_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded), check latency and write-back, then check that
    // done drops while wb_addr/wb_data hold. poke_at >= 0 pulses a stray
    // start with different operands at that point of the calculation.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_data,
                             input logic [4:0] exp_addr, input int poke_at);
        int lat = 1;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                @(negedge clk);
                start = 1'b1; funct3 = RVM_DIVU; op_a = 32'd1234; op_b = 32'd5; rd_in = 5'd9;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " done"},    {31'b0, done}, 32'd1);
        chk({tag, " busy"},    {31'b0, busy}, 32'd1);
        chk({tag, " data"},    wb_data, exp_data);
        chk({tag, " addr"},    {27'b0, wb_addr}, {27'b0, exp_addr});
        chk({tag, " we"},      {31'b0, wb_we}, {31'b0, (exp_addr != 5'd0)});
        @(posedge clk); #1;
        chk({tag, " done drop"}, {31'b0, done}, 32'd0);
        chk({tag, " we drop"},   {31'b0, wb_we}, 32'd0);
        chk({tag, " idle"},      {31'b0, busy}, 32'd0);
        chk({tag, " data hold"}, wb_data, exp_data);
        chk({tag, " addr hold"}, {27'b0, wb_addr}, {27'b0, exp_addr});
    endtask

    initial begin
        int seen;
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset we",   {31'b0, wb_we}, 32'd0);
        chk("reset data", wb_data, 32'd0);
        chk("reset addr", {27'b0, wb_addr}, 32'd0);
        #12 rst_n = 1'b1;

        // Multiply group
        issue(RVM_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
        wait_done("mul 7*-3", 33, 32'hFFFF_FFEB, 5'd5, -1);
        issue(RVM_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6);
        wait_done("mulh min*min", 33, 32'h4000_0000, 5'd6, -1);
        issue(RVM_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        wait_done("mulhu", 33, 32'hFFFF_FFFE, 5'd7, -1);
        issue(RVM_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        wait_done("mulhsu", 33, 32'hFFFF_FFFF, 5'd8, -1);

        // Divide group
        issue(RVM_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10);
        wait_done("div -7/2", 33, 32'hFFFF_FFFD, 5'd10, -1);
        issue(RVM_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
        wait_done("rem -7/2", 33, 32'hFFFF_FFFF, 5'd11, -1);
        issue(RVM_DIVU, 32'd100, 32'd7, 5'd12);
        wait_done("divu 100/7", 33, 32'd14, 5'd12, -1);
        issue(RVM_REMU, 32'd100, 32'd7, 5'd13);
        wait_done("remu 100/7", 33, 32'd2, 5'd13, -1);

        // Special cases finish the cycle after acceptance
        issue(RVM_DIVU, 32'd5, 32'd0, 5'd14);
        wait_done("divu by 0", 1, 32'hFFFF_FFFF, 5'd14, -1);
        issue(RVM_REM, 32'd5, 32'd0, 5'd15);
        wait_done("rem by 0", 1, 32'd5, 5'd15, -1);
        issue(RVM_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        wait_done("div ovf", 1, 32'h8000_0000, 5'd16, -1);
        issue(RVM_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
        wait_done("rem ovf", 1, 32'd0, 5'd17, -1);

        // rd = 0: done fires but no write enable
        issue(RVM_MUL, 32'd3, 32'd4, 5'd0);
        wait_done("mul rd0", 33, 32'd12, 5'd0, -1);

        // Stray start during CALC is ignored
        issue(RVM_MUL, 32'd1000, 32'd1000, 5'd3);
        wait_done("start in calc", 33, 32'd1000000, 5'd3, 10);

        // flush + start in IDLE: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = RVM_MUL; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {31'b0, busy}, 32'd0);

        // flush mid-calculation
        issue(RVM_DIVU, 32'd1000, 32'd3, 5'd4);
        repeat (14) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush done", {31'b0, done}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("flush no done", 32'(seen), 32'd0);
        chk("flush data kept", wb_data, 32'd1000000);
        issue(RVM_DIVU, 32'd9, 32'd3, 5'd2);
        wait_done("divu after flush", 33, 32'd3, 5'd2, -1);

        // Asynchronous reset mid-calculation
        issue(RVM_MUL, 32'd5, 32'd6, 5'd7);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst we",   {31'b0, wb_we}, 32'd0);
        chk("rst data", wb_data, 32'd0);
        chk("rst addr", {27'b0, wb_addr}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        issue(RVM_REMU, 32'd100, 32'd7, 5'd20);
        wait_done("remu after rst", 33, 32'd2, 5'd20, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
